// File: rtl/dynode_trigger_pkg.sv
// dynode_trigger_pkg: shared constants, bus layout and helpers for the
// dynode-channel trigger discriminator (dynode_trigger, dynode_baseline).
package dynode_trigger_pkg;

  // Datapath widths
  localparam int unsigned SAMPLE_W  = 8;
  localparam int unsigned OFFSET_W  = 6;
  localparam int unsigned SUM_W     = 12;
  localparam int unsigned BLK_CNT_W = 4;   // 16-sample baseline blocks
  localparam int unsigned BLOCK_LEN = 16;
  localparam int unsigned REG_W     = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned CTRL_W    = 2;
  localparam int unsigned IBUS_W    = 2 + ADDR_W + REG_W;
  localparam int unsigned MEAN_W    = SUM_W - BLK_CNT_W;

  // Register offsets from BASE
  localparam logic [ADDR_W-1:0] REG_THRESH  = 16'd0;
  localparam logic [ADDR_W-1:0] REG_HOLDOFF = 16'd1;
  localparam logic [ADDR_W-1:0] REG_CTRL    = 16'd2;
  localparam logic [ADDR_W-1:0] REG_COUNT   = 16'd3;
  localparam logic [ADDR_W-1:0] REG_OFFSET  = 16'd4;

  // Power-up values
  localparam logic [SAMPLE_W-1:0] THRESH_RST  = 8'd20;
  localparam logic [SAMPLE_W-1:0] HOLDOFF_RST = 8'd16;
  localparam logic [CTRL_W-1:0]   CTRL_RST    = 2'b01;  // enabled, not frozen

  localparam logic [OFFSET_W-1:0] OFFSET_MAX = '1;

  // Register-file bus payload, MSB first
  typedef struct packed {
    logic              bus_clk;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wrdata;
  } ibus_t;

  // Block mean (sum/16) saturated to the offset range
  function automatic logic [OFFSET_W-1:0] clamp_offset(input logic [SUM_W-1:0] sum);
    logic [MEAN_W-1:0] mean;
    mean = sum[SUM_W-1:BLK_CNT_W];
    return (mean > MEAN_W'(OFFSET_MAX)) ? OFFSET_MAX : mean[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dynode_baseline.sv
// dynode_baseline: baseline estimator. Accumulates s0 over consecutive
// 16-sample blocks and, at the end of a block in which diff_ok held on every
// cycle, loads offset with the clamped block mean. freeze holds offset and
// restarts block accumulation.
// Ports: clk, reset (async, active-high), s0 (registered sample),
//        diff_ok (cycle is quiet), freeze, offset (registered estimate).
module dynode_baseline
  import dynode_trigger_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] s0,
  input  logic                diff_ok,
  input  logic                freeze,
  output logic [OFFSET_W-1:0] offset
);

  logic [BLK_CNT_W-1:0] blk_cnt;
  logic [SUM_W-1:0]     sum;
  logic                 clean;
  logic [SUM_W-1:0]     sum_next;
  logic                 clean_next;

  // Current cycle folded in, so the block-end decision sees all 16 samples
  assign sum_next   = sum + SUM_W'(s0);
  assign clean_next = clean & diff_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
      sum     <= '0;
      clean   <= 1'b1;
      offset  <= '0;
    end else if (freeze) begin
      blk_cnt <= '0;
      sum     <= '0;
      clean   <= 1'b1;
    end else if (blk_cnt == BLK_CNT_W'(BLOCK_LEN - 1)) begin
      if (clean_next) offset <= clamp_offset(sum_next);
      blk_cnt <= '0;
      sum     <= '0;
      clean   <= 1'b1;
    end else begin
      blk_cnt <= blk_cnt + BLK_CNT_W'(1);
      sum     <= sum_next;
      clean   <= clean_next;
    end
  end

endmodule

// File: rtl/dynode_trigger.sv
// dynode_trigger: dynode-channel trigger discriminator. Subtracts a tracked
// baseline from each ADC sample and emits a one-cycle single pulse on each
// rising threshold crossing, with programmable holdoff. Registers at
// BASE..BASE+4 on the shared register-file bus.
// Ports: clk, reset (async, active-high), ibus {bus clk, wr, addr, wrdata},
//        obus (combinational read data, z when addr is not decoded),
//        data_in (ADC sample), single (trigger pulse), offset (baseline).
// Build option: DYNODE_TRIGGER_COUNTER_EN adds the trigger count register at
// BASE+3; without it BASE+3 is undecoded.
module dynode_trigger
  import dynode_trigger_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0040
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IBUS_W-1:0]   ibus,
  output logic [REG_W-1:0]    obus,
  input  logic [SAMPLE_W-1:0] data_in,
  output logic                single,
  output logic [OFFSET_W-1:0] offset
);

  localparam logic [ADDR_W-1:0] A_THRESH  = BASE + REG_THRESH;
  localparam logic [ADDR_W-1:0] A_HOLDOFF = BASE + REG_HOLDOFF;
  localparam logic [ADDR_W-1:0] A_CTRL    = BASE + REG_CTRL;
  localparam logic [ADDR_W-1:0] A_COUNT   = BASE + REG_COUNT;
  localparam logic [ADDR_W-1:0] A_OFFSET  = BASE + REG_OFFSET;

  ibus_t bus;
  assign bus = ibus;

  // The bus clock bit and the high write-data byte carry nothing for this block
  logic unused_bus;
  assign unused_bus = &{1'b0, bus.bus_clk, bus.wrdata[REG_W-1:SAMPLE_W]};

  // Configuration registers
  logic [SAMPLE_W-1:0] threshold;
  logic [SAMPLE_W-1:0] holdoff;
  logic [CTRL_W-1:0]   ctrl;
  logic                enable;
  logic                freeze;

  assign enable = ctrl[0];
  assign freeze = ctrl[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      threshold <= THRESH_RST;
      holdoff   <= HOLDOFF_RST;
      ctrl      <= CTRL_RST;
    end else if (bus.wr) begin
      if (bus.addr == A_THRESH)  threshold <= bus.wrdata[SAMPLE_W-1:0];
      if (bus.addr == A_HOLDOFF) holdoff   <= bus.wrdata[SAMPLE_W-1:0];
      if (bus.addr == A_CTRL)    ctrl      <= bus.wrdata[CTRL_W-1:0];
    end
  end

  // Sample path: s0 -> diff (baseline removed, floored at 0) -> prev
  logic [SAMPLE_W-1:0] s0;
  logic [SAMPLE_W-1:0] diff_c;
  logic [SAMPLE_W-1:0] diff;
  logic [SAMPLE_W-1:0] prev;
  logic [SAMPLE_W-1:0] hold_cnt;
  logic                trig_c;
  logic                diff_ok_c;

  assign diff_c = (s0 >= SAMPLE_W'(offset)) ? (s0 - SAMPLE_W'(offset)) : '0;

  // Rising crossing only; threshold 0 can never satisfy prev < threshold
  assign trig_c = enable && (diff >= threshold) && (prev < threshold) &&
                  (hold_cnt == '0);

  // Quiet cycle for the baseline: nothing above threshold, no holdoff pending
  assign diff_ok_c = (diff_c < threshold) && (hold_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0       <= '0;
      diff     <= '0;
      prev     <= '0;
      single   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      s0     <= data_in;
      diff   <= diff_c;
      prev   <= diff;
      single <= trig_c;
      if (trig_c)                hold_cnt <= holdoff;
      else if (hold_cnt != '0)   hold_cnt <= hold_cnt - SAMPLE_W'(1);
    end
  end

  dynode_baseline u_baseline (
    .clk     (clk),
    .reset   (reset),
    .s0      (s0),
    .diff_ok (diff_ok_c),
    .freeze  (freeze),
    .offset  (offset)
  );

`ifdef DYNODE_TRIGGER_COUNTER_EN
  // Trigger count; a write to its address clears it and beats a same-cycle trigger
  logic [REG_W-1:0] trig_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                trig_count <= '0;
    else if (bus.wr && (bus.addr == A_COUNT)) trig_count <= '0;
    else if (trig_c)                          trig_count <= trig_count + REG_W'(1);
  end
`endif

  // Combinational read mux
  logic             rd_hit;
  logic [REG_W-1:0] rd_data;

  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    if (bus.addr == A_THRESH)       rd_data = REG_W'(threshold);
    else if (bus.addr == A_HOLDOFF) rd_data = REG_W'(holdoff);
    else if (bus.addr == A_CTRL)    rd_data = REG_W'(ctrl);
`ifdef DYNODE_TRIGGER_COUNTER_EN
    else if (bus.addr == A_COUNT)   rd_data = trig_count;
`endif
    else if (bus.addr == A_OFFSET)  rd_data = REG_W'(offset);
    else                            rd_hit  = 1'b0;
  end

  assign obus = rd_hit ? rd_data : {REG_W{1'bz}};

endmodule

// File: tb/tb_dynode_trigger.sv
// tb_dynode_trigger: directed self-checking bench for dynode_trigger.
module tb_dynode_trigger;

  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] ibus;
  logic [15:0] obus;
  logic [7:0]  data_in;
  logic        single;
  logic [5:0]  offset;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int p0;

  dynode_trigger #(.BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .ibus    (ibus),
    .obus    (obus),
    .data_in (data_in),
    .single  (single),
    .offset  (offset)
  );

  always #5 clk = ~clk;

  // Pulses are one cycle wide, so one sample per cycle counts each once
  always @(negedge clk) if (single === 1'b1) pulse_cnt++;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Undecoded address: floating bus (a 2-state model resolves it to 0)
  task automatic check_z(input string tag, input logic [15:0] obs);
    n_checks++;
    assert (obs === 16'hzzzz || obs === 16'h0000) n_pass++;
    else $error("FAIL %s observed=%h expected=zzzz", tag, obs);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the write lands on the following rising edge
  task automatic wr_reg(input logic [15:0] off, input logic [15:0] d);
    ibus = {1'b0, 1'b1, BASE + off, d};
    @(negedge clk);
    ibus = {1'b0, 1'b0, BASE + off, 16'h0000};
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] off, input logic [15:0] exp);
    ibus = {1'b0, 1'b0, BASE + off, 16'h0000};
    #1;
    check(tag, obus, exp);
  endtask

  task automatic rd_chk_z(input string tag, input logic [15:0] off);
    ibus = {1'b0, 1'b0, BASE + off, 16'h0000};
    #1;
    check_z(tag, obus);
  endtask

  initial begin
    reset   = 1'b1;
    ibus    = '0;
    data_in = 8'd10;

    // Reset state and register power-up values
    @(negedge clk);
    check("rst_single", {15'd0, single}, 16'd0);
    check("rst_offset", {10'd0, offset}, 16'd0);
    reset = 1'b0;
    rd_chk("rd_thresh", 16'd0, 16'd20);
    rd_chk("rd_holdoff", 16'd1, 16'd16);
    rd_chk("rd_ctrl", 16'd2, 16'd1);
`ifdef DYNODE_TRIGGER_COUNTER_EN
    rd_chk("rd_count", 16'd3, 16'd0);
`else
    rd_chk_z("rd_count_undecoded", 16'd3);
`endif
    rd_chk("rd_offset", 16'd4, 16'd0);
    rd_chk_z("rd_base5", 16'd5);

    // Baseline: 10s converge to offset 10 within two block ends
    tick(40);
    check("offset_clean", {10'd0, offset}, 16'd10);

    // 200 for 16 cycles: blocks are dirty, offset holds; step fires once
    p0 = pulse_cnt;
    data_in = 8'd200;
    tick(16);
    check("offset_dirty_hold", {10'd0, offset}, 16'd10);
    data_in = 8'd10;
    tick(40);
    check("offset_recover", {10'd0, offset}, 16'd10);
    check("dirty_step_pulse", 16'(pulse_cnt - p0), 16'd1);
    wr_reg(16'd3, 16'h0000);

    // Step 10 -> 40 held: one pulse, two clocks after capture
    p0 = pulse_cnt;
    data_in = 8'd40;
    tick(2);
    check("step_not_yet", {15'd0, single}, 16'd0);
    tick(1);
    check("step_fire", {15'd0, single}, 16'd1);
    tick(1);
    check("step_one_wide", {15'd0, single}, 16'd0);
    tick(46);
    check("step_one_pulse", 16'(pulse_cnt - p0), 16'd1);
`ifdef DYNODE_TRIGGER_COUNTER_EN
    rd_chk("count_after_step", 16'd3, 16'd1);
    tick(1);
`endif
    data_in = 8'd10;
    tick(30);
    wr_reg(16'd3, 16'h0000);

    // Holdoff 4: second crossing lands on the last blocked cycle
    wr_reg(16'd1, 16'd4);
    tick(5);
    p0 = pulse_cnt;
    data_in = 8'd40; tick(2);
    data_in = 8'd10; tick(2);
    data_in = 8'd40; tick(2);
    data_in = 8'd10; tick(10);
    check("holdoff4_one", 16'(pulse_cnt - p0), 16'd1);

    // Holdoff 0: both crossings fire
    wr_reg(16'd1, 16'd0);
    tick(5);
    p0 = pulse_cnt;
    data_in = 8'd40; tick(2);
    data_in = 8'd10; tick(2);
    data_in = 8'd40; tick(2);
    data_in = 8'd10; tick(10);
    check("holdoff0_two", 16'(pulse_cnt - p0), 16'd2);
`ifdef DYNODE_TRIGGER_COUNTER_EN
    rd_chk("count_three", 16'd3, 16'd3);
    tick(1);
`endif

    // Count clear on the same edge as a trigger: clear wins
    data_in = 8'd40;
    tick(2);
    ibus = {1'b0, 1'b1, BASE + 16'd3, 16'h0000};
    tick(1);
    ibus = {1'b0, 1'b0, BASE + 16'd3, 16'h0000};
    check("clr_trig_fire", {15'd0, single}, 16'd1);
`ifdef DYNODE_TRIGGER_COUNTER_EN
    rd_chk("clr_wins", 16'd3, 16'd0);
    tick(1);
`endif
    data_in = 8'd10;
    tick(5);

    // Enable cleared: no triggers
    wr_reg(16'd2, 16'd0);
    p0 = pulse_cnt;
    data_in = 8'd40; tick(6);
    data_in = 8'd10; tick(4);
    data_in = 8'd40; tick(6);
    data_in = 8'd10; tick(4);
    check("disabled_no_trig", 16'(pulse_cnt - p0), 16'd0);

    // Threshold 0 never triggers
    wr_reg(16'd2, 16'd1);
    wr_reg(16'd0, 16'd0);
    tick(4);
    p0 = pulse_cnt;
    data_in = 8'd40; tick(6);
    data_in = 8'd10; tick(6);
    check("thresh0_no_trig", 16'(pulse_cnt - p0), 16'd0);
    wr_reg(16'd0, 16'd20);

    // Reset while the pulse is high and holdoff is loaded
    wr_reg(16'd1, 16'd50);
    tick(4);
    data_in = 8'd40;
    tick(2);
    @(posedge clk);
    #2;
    check("pre_reset_fire", {15'd0, single}, 16'd1);
    reset = 1'b1;
    data_in = 8'd10;
    #1;
    check("rst_mid_single", {15'd0, single}, 16'd0);
    check("rst_mid_offset", {10'd0, offset}, 16'd0);
    rd_chk("rst_mid_thresh", 16'd0, 16'd20);
    rd_chk("rst_mid_holdoff", 16'd1, 16'd16);
    @(negedge clk);
    reset = 1'b0;
    tick(3);

    // Next crossing after release fires normally (offset 0, threshold 20)
    data_in = 8'd40;
    tick(2);
    check("post_rst_not_yet", {15'd0, single}, 16'd0);
    tick(1);
    check("post_rst_fire", {15'd0, single}, 16'd1);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
